// File: rtl/e_m_reg.sv
`default_nettype none
// ============================================================================
// Module      : e_m_reg
// Description : E->M pipeline register with exception merge, Tnew countdown
//               and flush-to-handler on an interrupt/exception request.
// Revision    : 1.0 - initial release
// ============================================================================
module e_m_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        en,
    input  logic [31:0] E_pc,
    input  logic [31:0] E_instr,
    input  logic [31:0] E_ALUresult,
    input  logic [31:0] E_rt_data,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic        E_BD,
    input  logic        E_Exc_in,
    input  logic [4:0]  E_ExcCode_in,
    input  logic        E_Exc_Ov,
    input  logic        E_Exc_Ovload,
    input  logic        E_Exc_Ovstore,
    output logic [31:0] M_pc,
    output logic [31:0] M_instr,
    output logic [31:0] M_ALUresult,
    output logic [31:0] M_rt_data,
    output logic [4:0]  M_A3,
    output logic [1:0]  M_Tnew,
    output logic        M_BD,
    output logic        M_Exc,
    output logic [4:0]  M_ExcCode
);

    localparam logic [31:0] c_HANDLER_PC     = 32'h0000_4180;
    localparam logic [4:0]  c_EXCCODE_NONE   = 5'd0;
    localparam logic [4:0]  c_EXCCODE_ADEL   = 5'd4;
    localparam logic [4:0]  c_EXCCODE_ADES   = 5'd5;
    localparam logic [4:0]  c_EXCCODE_OV     = 5'd12;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] alu_q;
    logic [31:0] rt_data_q;
    logic [4:0]  a3_q;
    logic [1:0]  tnew_q;
    logic        bd_q;
    logic        exc_q;
    logic [4:0]  exccode_q;

    logic        exc_d;
    logic [4:0]  exccode_d;
    logic [4:0]  a3_d;
    logic [1:0]  tnew_d;

    // An earlier-stage exception always wins over anything the ALU reports.
    always_comb begin
        exc_d     = 1'b1;
        exccode_d = c_EXCCODE_NONE;
        if (E_Exc_in) begin
            exccode_d = E_ExcCode_in;
        end else if (E_Exc_Ov) begin
            exccode_d = c_EXCCODE_OV;
        end else if (E_Exc_Ovload) begin
            exccode_d = c_EXCCODE_ADEL;
        end else if (E_Exc_Ovstore) begin
            exccode_d = c_EXCCODE_ADES;
        end else begin
            exc_d = 1'b0;
        end
    end

    // A faulting instruction must neither write back nor forward.
    always_comb begin
        a3_d   = exc_d ? 5'd0 : E_A3;
        tnew_d = 2'd0;
        if (!exc_d && (E_Tnew != 2'd0)) begin
            tnew_d = E_Tnew - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= 32'd0;
            instr_q   <= 32'd0;
            alu_q     <= 32'd0;
            rt_data_q <= 32'd0;
            a3_q      <= 5'd0;
            tnew_q    <= 2'd0;
            bd_q      <= 1'b0;
            exc_q     <= 1'b0;
            exccode_q <= c_EXCCODE_NONE;
        end else if (Req) begin
            pc_q      <= c_HANDLER_PC;
            instr_q   <= 32'd0;
            alu_q     <= 32'd0;
            rt_data_q <= 32'd0;
            a3_q      <= 5'd0;
            tnew_q    <= 2'd0;
            bd_q      <= 1'b0;
            exc_q     <= 1'b0;
            exccode_q <= c_EXCCODE_NONE;
        end else if (en) begin
            pc_q      <= E_pc;
            instr_q   <= E_instr;
            alu_q     <= E_ALUresult;
            rt_data_q <= E_rt_data;
            a3_q      <= a3_d;
            tnew_q    <= tnew_d;
            bd_q      <= E_BD;
            exc_q     <= exc_d;
            exccode_q <= exccode_d;
        end
    end

    assign M_pc        = pc_q;
    assign M_instr     = instr_q;
    assign M_ALUresult = alu_q;
    assign M_rt_data   = rt_data_q;
    assign M_A3        = a3_q;
    assign M_Tnew      = tnew_q;
    assign M_BD        = bd_q;
    assign M_Exc       = exc_q;
    assign M_ExcCode   = exccode_q;

endmodule
`default_nettype wire

// File: tb/tb_e_m_reg.sv
`default_nettype none
// Directed testbench for e_m_reg: each task drives one scenario and checks
// the registered outputs one time unit after the capturing edge.
module tb_e_m_reg;

    logic        clk = 1'b0;
    logic        reset, Req, en;
    logic [31:0] E_pc, E_instr, E_ALUresult, E_rt_data;
    logic [4:0]  E_A3, E_ExcCode_in;
    logic [1:0]  E_Tnew;
    logic        E_BD, E_Exc_in, E_Exc_Ov, E_Exc_Ovload, E_Exc_Ovstore;
    logic [31:0] M_pc, M_instr, M_ALUresult, M_rt_data;
    logic [4:0]  M_A3, M_ExcCode;
    logic [1:0]  M_Tnew;
    logic        M_BD, M_Exc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    e_m_reg dut (
        .clk(clk), .reset(reset), .Req(Req), .en(en),
        .E_pc(E_pc), .E_instr(E_instr), .E_ALUresult(E_ALUresult),
        .E_rt_data(E_rt_data), .E_A3(E_A3), .E_Tnew(E_Tnew), .E_BD(E_BD),
        .E_Exc_in(E_Exc_in), .E_ExcCode_in(E_ExcCode_in),
        .E_Exc_Ov(E_Exc_Ov), .E_Exc_Ovload(E_Exc_Ovload),
        .E_Exc_Ovstore(E_Exc_Ovstore),
        .M_pc(M_pc), .M_instr(M_instr), .M_ALUresult(M_ALUresult),
        .M_rt_data(M_rt_data), .M_A3(M_A3), .M_Tnew(M_Tnew), .M_BD(M_BD),
        .M_Exc(M_Exc), .M_ExcCode(M_ExcCode)
    );

    task automatic clear_exc();
        E_Exc_in = 0; E_ExcCode_in = 0; E_Exc_Ov = 0; E_Exc_Ovload = 0; E_Exc_Ovstore = 0;
    endtask

    task automatic set_inst(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] a3,
                            input logic [1:0] tnew);
        E_pc = pc; E_instr = pc ^ 32'hA5A5_0000; E_ALUresult = alu;
        E_rt_data = alu + 32'h100; E_A3 = a3; E_Tnew = tnew; E_BD = pc[2];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; Req = 1; en = 1; clear_exc(); E_Exc_Ov = 1;
        set_inst(32'h3004, 32'h55, 5'd9, 2'd2);
        step();
        total++; if (M_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", M_pc); end
        total++; if (M_instr !== 32'h0 || M_ALUresult !== 32'h0 || M_rt_data !== 32'h0) begin bad++;
            $display("FAIL reset_data: got %h %h %h want 0", M_instr, M_ALUresult, M_rt_data); end
        total++; if (M_A3 !== 5'd0 || M_Tnew !== 2'd0 || M_BD !== 1'b0) begin bad++;
            $display("FAIL reset_ctl: got a3=%0d tnew=%0d bd=%b want 0", M_A3, M_Tnew, M_BD); end
        total++; if (M_Exc !== 1'b0 || M_ExcCode !== 5'd0) begin bad++;
            $display("FAIL reset_exc: got exc=%b code=%0d want 0", M_Exc, M_ExcCode); end
        reset = 0; Req = 0; clear_exc();
    endtask

    task automatic test_capture();
        en = 1; set_inst(32'h3000, 32'h1234, 5'd5, 2'd2); E_BD = 1;
        step();
        total++; if (M_pc !== 32'h3000) begin bad++; $display("FAIL cap_pc: got %h want 3000", M_pc); end
        total++; if (M_ALUresult !== 32'h1234) begin bad++; $display("FAIL cap_alu: got %h want 1234", M_ALUresult); end
        total++; if (M_instr !== 32'hA5A5_3000 || M_rt_data !== 32'h1334 || M_BD !== 1'b1) begin bad++;
            $display("FAIL cap_misc: got %h %h %b want a5a53000 1334 1", M_instr, M_rt_data, M_BD); end
        total++; if (M_A3 !== 5'd5 || M_Tnew !== 2'd1) begin bad++;
            $display("FAIL cap_a3_tnew: got %0d %0d want 5 1", M_A3, M_Tnew); end
        total++; if (M_Exc !== 1'b0 || M_ExcCode !== 5'd0) begin bad++;
            $display("FAIL cap_exc: got %b %0d want 0 0", M_Exc, M_ExcCode); end
    endtask

    task automatic test_tnew();
        logic [1:0] tin [3];
        logic [1:0] tout [3];
        tin[0] = 2'd0; tout[0] = 2'd0;
        tin[1] = 2'd1; tout[1] = 2'd0;
        tin[2] = 2'd3; tout[2] = 2'd2;
        for (int i = 0; i < 3; i++) begin
            set_inst(32'h3010 + 32'(i * 4), 32'h40, 5'd3, tin[i]);
            step();
            total++; if (M_Tnew !== tout[i] || M_A3 !== 5'd3) begin bad++;
                $display("FAIL tnew_%0d: got tnew=%0d a3=%0d want %0d 3", tin[i], M_Tnew, M_A3, tout[i]); end
        end
    endtask

    task automatic test_exc();
        // {Exc_in, Ov, Ovload, Ovstore}, incoming code, expected code
        logic [3:0] flags [7];
        logic [4:0] expc  [7];
        flags[0] = 4'b0010; expc[0] = 5'd4;
        flags[1] = 4'b1010; expc[1] = 5'd10;
        flags[2] = 4'b0001; expc[2] = 5'd5;
        flags[3] = 4'b0101; expc[3] = 5'd12;
        flags[4] = 4'b0111; expc[4] = 5'd12;
        flags[5] = 4'b0011; expc[5] = 5'd4;
        flags[6] = 4'b1111; expc[6] = 5'd10;
        for (int i = 0; i < 7; i++) begin
            set_inst(32'h3100 + 32'(i * 4), 32'h8000_0000, 5'd8, 2'd2);
            {E_Exc_in, E_Exc_Ov, E_Exc_Ovload, E_Exc_Ovstore} = flags[i];
            E_ExcCode_in = 5'd10;
            step();
            total++; if (M_Exc !== 1'b1 || M_ExcCode !== expc[i]) begin bad++;
                $display("FAIL exc_code_%0d: got exc=%b code=%0d want 1 %0d", i, M_Exc, M_ExcCode, expc[i]); end
            total++; if (M_A3 !== 5'd0 || M_Tnew !== 2'd0 || M_pc !== 32'h3100 + 32'(i * 4)) begin bad++;
                $display("FAIL exc_kill_%0d: got a3=%0d tnew=%0d pc=%h", i, M_A3, M_Tnew, M_pc); end
        end
        clear_exc(); E_ExcCode_in = 5'd10;
        set_inst(32'h3200, 32'h1, 5'd8, 2'd1);
        step();
        total++; if (M_Exc !== 1'b0 || M_ExcCode !== 5'd0 || M_A3 !== 5'd8) begin bad++;
            $display("FAIL exc_clear: got exc=%b code=%0d a3=%0d want 0 0 8", M_Exc, M_ExcCode, M_A3); end
        E_ExcCode_in = 0;
    endtask

    task automatic test_req();
        en = 1; Req = 1; set_inst(32'h3300, 32'h77, 5'd7, 2'd2); E_BD = 1; E_Exc_Ov = 1;
        step();
        total++; if (M_pc !== 32'h0000_4180) begin bad++; $display("FAIL req_pc: got %h want 4180", M_pc); end
        total++; if (M_instr !== 0 || M_ALUresult !== 0 || M_rt_data !== 0 || M_A3 !== 0 || M_Tnew !== 0
                     || M_BD !== 0 || M_Exc !== 0 || M_ExcCode !== 0) begin bad++;
            $display("FAIL req_zero: got %h %h %h %0d %0d %b %b %0d", M_instr, M_ALUresult, M_rt_data,
                     M_A3, M_Tnew, M_BD, M_Exc, M_ExcCode); end
        Req = 0; clear_exc(); set_inst(32'h3304, 32'h78, 5'd7, 2'd2);
        step();
        en = 0; Req = 1;
        step();
        total++; if (M_pc !== 32'h0000_4180 || M_ALUresult !== 32'h0 || M_A3 !== 5'd0) begin bad++;
            $display("FAIL req_en0: got pc=%h alu=%h a3=%0d want 4180 0 0", M_pc, M_ALUresult, M_A3); end
        en = 1; reset = 1;
        step();
        total++; if (M_pc !== 32'h0) begin bad++; $display("FAIL reset_over_req: got %h want 0", M_pc); end
        reset = 0; Req = 0;
        set_inst(32'h3308, 32'h79, 5'd6, 2'd1);
        step();
        total++; if (M_pc !== 32'h3308 || M_A3 !== 5'd6) begin bad++;
            $display("FAIL resume_after_reset: got pc=%h a3=%0d want 3308 6", M_pc, M_A3); end
    endtask

    task automatic test_hold();
        en = 1; set_inst(32'h3400, 32'hCAFE, 5'd12, 2'd2);
        step();
        en = 0;
        for (int i = 0; i < 3; i++) begin
            set_inst(32'h5000 + 32'(i), 32'h9999 + 32'(i), 5'd31, 2'd3);
            E_Exc_Ovload = (i == 1); E_Exc_Ov = (i == 2);
            step();
            total++; if (M_pc !== 32'h3400 || M_ALUresult !== 32'hCAFE || M_A3 !== 5'd12
                         || M_Tnew !== 2'd1 || M_Exc !== 1'b0 || M_ExcCode !== 5'd0) begin bad++;
                $display("FAIL hold_%0d: got pc=%h alu=%h a3=%0d tnew=%0d exc=%b code=%0d", i,
                         M_pc, M_ALUresult, M_A3, M_Tnew, M_Exc, M_ExcCode); end
        end
        clear_exc();
    endtask

    task automatic test_reset_mid();
        en = 1; set_inst(32'h3500, 32'hBEEF, 5'd4, 2'd2); E_Exc_Ovstore = 1;
        step();
        en = 0; clear_exc(); reset = 1;
        step();
        total++; if (M_pc !== 0 || M_ALUresult !== 0 || M_Exc !== 0 || M_ExcCode !== 0 || M_BD !== 0) begin bad++;
            $display("FAIL reset_mid: got pc=%h alu=%h exc=%b code=%0d bd=%b", M_pc, M_ALUresult,
                     M_Exc, M_ExcCode, M_BD); end
        reset = 0; en = 1; set_inst(32'h3504, 32'h10, 5'd2, 2'd0);
        step();
        total++; if (M_pc !== 32'h3504 || M_A3 !== 5'd2 || M_Tnew !== 2'd0) begin bad++;
            $display("FAIL reset_mid_resume: got pc=%h a3=%0d tnew=%0d want 3504 2 0", M_pc, M_A3, M_Tnew); end
    endtask

    initial begin
        reset = 1; Req = 0; en = 0; clear_exc();
        set_inst(32'h0, 32'h0, 5'd0, 2'd0);
        test_reset();
        test_capture();
        test_tnew();
        test_exc();
        test_req();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
